// File: rtl/bp_fe_pkg.sv
// Shared types and helpers for the front-end gshare branch history table.
package bp_fe_pkg;

  typedef enum logic [0:0] {
    e_bht_init,
    e_bht_ready
  } bp_fe_bht_state_e;

  // Weakly-not-taken counter value: 2**(w-1)-1, e.g. 2'b01 for 2-bit counters.
  function automatic int unsigned bht_ctr_init_val(input int unsigned ctr_width);
    return (32'd1 << (ctr_width - 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/bp_fe_bht_ctr_sat.sv
// Combinational saturating up/down counter update for one BHT entry.
module bp_fe_bht_ctr_sat #(
  parameter int unsigned ctr_width_p = 2
) (
  input  logic [ctr_width_p-1:0] ctr_i,
  input  logic                   taken_i,
  output logic [ctr_width_p-1:0] ctr_o
);

  localparam logic [ctr_width_p-1:0] CtrMax = '1;
  localparam logic [ctr_width_p-1:0] CtrOne = ctr_width_p'(1);

  // Step toward taken/not-taken, holding at either rail.
  always_comb begin
    ctr_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != CtrMax) ctr_o = ctr_i + CtrOne;
    end else begin
      if (ctr_i != '0) ctr_o = ctr_i - CtrOne;
    end
  end

endmodule

// File: rtl/bp_fe_bht_gshare.sv
// Gshare branch history table: speculative global history, table of saturating
// counters indexed by PC index XOR history, registered predictions, and a
// one-entry-per-cycle init sweep after reset.
module bp_fe_bht_gshare
  import bp_fe_pkg::*;
#(
  parameter int unsigned bht_idx_width_p = 9,
  parameter int unsigned ghist_width_p   = 5,
  parameter int unsigned ctr_width_p     = 2
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  output logic                       init_done_o,
  input  logic                       r_v_i,
  input  logic [bht_idx_width_p-1:0] idx_r_i,
  output logic                       predict_v_o,
  output logic                       predict_o,
  output logic [ghist_width_p-1:0]   ghist_o,
  input  logic                       spec_v_i,
  input  logic                       spec_taken_i,
  input  logic                       w_v_i,
  input  logic [bht_idx_width_p-1:0] idx_w_i,
  input  logic [ghist_width_p-1:0]   ghist_w_i,
  input  logic                       taken_i,
  input  logic                       restore_v_i,
  input  logic [ghist_width_p-1:0]   restore_ghist_i
);

  localparam int unsigned Els = 2 ** bht_idx_width_p;
  localparam logic [ctr_width_p-1:0] CtrInit = ctr_width_p'(bht_ctr_init_val(ctr_width_p));
  localparam logic [bht_idx_width_p-1:0] IdxOne = bht_idx_width_p'(1);

  bp_fe_bht_state_e state_q, state_d;
  logic [bht_idx_width_p-1:0] init_ptr_q, init_ptr_d;
  logic [ghist_width_p-1:0]   ghist_q, ghist_d, ghist_shift;
  logic                       predict_v_q, predict_v_d;
  logic                       predict_q, predict_d;
  logic [ghist_width_p-1:0]   ghist_o_q, ghist_o_d;

  logic [ctr_width_p-1:0] mem_q [Els];

  logic                       ready;
  logic [bht_idx_width_p-1:0] r_hash, w_hash;
  logic [ctr_width_p-1:0]     r_ctr, w_ctr_old, w_ctr_new;
  logic                       wr_en;
  logic [bht_idx_width_p-1:0] wr_addr;
  logic [ctr_width_p-1:0]     wr_data;

  assign ready  = (state_q == e_bht_ready);
  // History sits in the low bits; the cast zero-extends it to index width.
  assign r_hash = idx_r_i ^ bht_idx_width_p'(ghist_q);
  assign w_hash = idx_w_i ^ bht_idx_width_p'(ghist_w_i);

  assign r_ctr     = mem_q[r_hash];
  assign w_ctr_old = mem_q[w_hash];

  bp_fe_bht_ctr_sat #(
    .ctr_width_p(ctr_width_p)
  ) u_ctr_sat (
    .ctr_i  (w_ctr_old),
    .taken_i(taken_i),
    .ctr_o  (w_ctr_new)
  );

  if (ghist_width_p == 1) begin : g_ghist_one
    assign ghist_shift = spec_taken_i;
  end else begin : g_ghist_many
    assign ghist_shift = {ghist_q[ghist_width_p-2:0], spec_taken_i};
  end

  // Init sweep walks every entry once, then the table stays ready until reset.
  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    unique case (state_q)
      e_bht_init: begin
        init_ptr_d = init_ptr_q + IdxOne;
        if (init_ptr_q == '1) state_d = e_bht_ready;
      end
      e_bht_ready: ;
      default: state_d = e_bht_init;
    endcase
  end

  // Single table write port: the sweep owns it until ready, then training.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = w_hash;
    wr_data = w_ctr_new;
    if (!ready) begin
      wr_en   = 1'b1;
      wr_addr = init_ptr_q;
      wr_data = CtrInit;
    end else if (w_v_i) begin
      wr_en = 1'b1;
    end
  end

  // Restore beats speculative shift; history is frozen during the sweep.
  always_comb begin
    ghist_d = ghist_q;
    if (ready) begin
      if (restore_v_i)   ghist_d = restore_ghist_i;
      else if (spec_v_i) ghist_d = ghist_shift;
    end
  end

  // Lookup reads pre-update counter and pre-update history (no bypass).
  always_comb begin
    predict_v_d = ready & r_v_i;
    predict_d   = predict_q;
    ghist_o_d   = ghist_o_q;
    if (predict_v_d) begin
      predict_d = r_ctr[ctr_width_p-1];
      ghist_o_d = ghist_q;
    end
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q     <= e_bht_init;
      init_ptr_q  <= '0;
      ghist_q     <= '0;
      predict_v_q <= 1'b0;
      predict_q   <= 1'b0;
      ghist_o_q   <= '0;
    end else begin
      state_q     <= state_d;
      init_ptr_q  <= init_ptr_d;
      ghist_q     <= ghist_d;
      predict_v_q <= predict_v_d;
      predict_q   <= predict_d;
      ghist_o_q   <= ghist_o_d;
    end
  end

  // Counter storage; contents are (re)established by the init sweep.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign init_done_o = ready;
  assign predict_v_o = predict_v_q;
  assign predict_o   = predict_q;
  assign ghist_o     = ghist_o_q;

endmodule

// File: tb/tb_bp_fe_bht_gshare.sv
// Scoreboard bench for bp_fe_bht_gshare: default instance plus a small
// 3-bit-counter instance with history as wide as the index.
module tb_bp_fe_bht_gshare;

  localparam int Els = 512;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n = 1'b0;
  logic       init_done, predict_v, predict;
  logic [4:0] ghist;
  logic       r_v = 0, spec_v = 0, spec_taken = 0, w_v = 0, taken = 0, restore_v = 0;
  logic [8:0] idx_r = '0, idx_w = '0;
  logic [4:0] ghist_w = '0, restore_ghist = '0;

  logic       init_done3, predict_v3, predict3;
  logic [3:0] ghist3;
  logic       r_v3 = 0, spec_v3 = 0, spec_taken3 = 0, w_v3 = 0, taken3 = 0;
  logic [3:0] idx_r3 = '0, idx_w3 = '0;

  bp_fe_bht_gshare dut (
    .clk_i(clk), .reset_n_i(reset_n), .init_done_o(init_done),
    .r_v_i(r_v), .idx_r_i(idx_r), .predict_v_o(predict_v), .predict_o(predict),
    .ghist_o(ghist), .spec_v_i(spec_v), .spec_taken_i(spec_taken), .w_v_i(w_v),
    .idx_w_i(idx_w), .ghist_w_i(ghist_w), .taken_i(taken), .restore_v_i(restore_v),
    .restore_ghist_i(restore_ghist)
  );

  bp_fe_bht_gshare #(
    .bht_idx_width_p(4), .ghist_width_p(4), .ctr_width_p(3)
  ) dut3 (
    .clk_i(clk), .reset_n_i(reset_n), .init_done_o(init_done3),
    .r_v_i(r_v3), .idx_r_i(idx_r3), .predict_v_o(predict_v3), .predict_o(predict3),
    .ghist_o(ghist3), .spec_v_i(spec_v3), .spec_taken_i(spec_taken3), .w_v_i(w_v3),
    .idx_w_i(idx_w3), .ghist_w_i(4'h0), .taken_i(taken3), .restore_v_i(1'b0),
    .restore_ghist_i(4'h0)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model of the default instance.
  typedef struct packed {
    logic       p;
    logic [4:0] gh;
  } exp_t;

  int         m_ctr [Els];
  logic [4:0] m_gh;
  exp_t       sb_q[$];
  exp_t       mon_e;

  task automatic model_reset();
    for (int i = 0; i < Els; i++) m_ctr[i] = 1;
    m_gh = '0;
  endtask

  // One cycle of traffic to the default instance; expectations use pre-edge state.
  task automatic drive(input logic rv, input logic [8:0] ri, input logic wv,
                       input logic [8:0] wi, input logic [4:0] wg, input logic tk,
                       input logic sv, input logic st, input logic rsv, input logic [4:0] rg);
    int   h;
    exp_t e;
    r_v = rv; idx_r = ri; w_v = wv; idx_w = wi; ghist_w = wg; taken = tk;
    spec_v = sv; spec_taken = st; restore_v = rsv; restore_ghist = rg;
    if (rv) begin
      h    = int'(ri ^ {4'b0, m_gh});
      e.p  = (m_ctr[h] >= 2);
      e.gh = m_gh;
      sb_q.push_back(e);
    end
    if (wv) begin
      h = int'(wi ^ {4'b0, wg});
      if (tk) begin
        if (m_ctr[h] < 3) m_ctr[h]++;
      end else if (m_ctr[h] > 0) m_ctr[h]--;
    end
    if (rsv)     m_gh = rg;
    else if (sv) m_gh = {m_gh[3:0], st};
    @(posedge clk); #1;
    r_v = 0; w_v = 0; spec_v = 0; restore_v = 0;
  endtask

  task automatic rd(input logic [8:0] ri);
    drive(1'b1, ri, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic tr(input logic [8:0] wi, input logic [4:0] wg, input logic tk);
    drive(1'b0, '0, 1'b1, wi, wg, tk, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Scoreboard: every prediction must match the oldest outstanding lookup.
  always @(negedge clk) begin
    if (predict_v === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_eq("pred_spurious", predict_v, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check_eq("pred_taken", predict, mon_e.p);
        check_eq("pred_ghist", ghist, mon_e.gh);
      end
    end
  end

  // Reset, then run the sweep, optionally with junk traffic that must be ignored.
  task automatic reset_and_sweep(input bit junk);
    int n;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_init_done", init_done, 0);
    check_eq("rst_predict_v", predict_v, 0);
    check_eq("rst_predict", predict, 0);
    check_eq("rst_ghist", ghist, 0);
    reset_n = 1'b1;
    if (junk) begin
      r_v = 1; w_v = 1; taken = 1; spec_v = 1; spec_taken = 1;
      restore_v = 1; restore_ghist = 5'h1f; ghist_w = 5'h0;
    end
    n = 0;
    while (init_done !== 1'b1 && n < 2000) begin
      if (junk) begin idx_r = 9'($urandom); idx_w = 9'($urandom); end
      @(posedge clk); #1;
      n++;
      if (n == 256) check_eq("sweep_mid_done", init_done, 0);
    end
    r_v = 0; w_v = 0; spec_v = 0; restore_v = 0;
    check_eq("sweep_len", n, Els);
    model_reset();
  endtask

  int m3;

  // 3-bit counter instance: train idx 3, then read it back the next cycle.
  task automatic train3_and_read(input logic tk, input logic [3:0] ri);
    w_v3 = 1; idx_w3 = 4'h3; taken3 = tk;
    if (tk) begin
      if (m3 < 7) m3++;
    end else if (m3 > 0) m3--;
    @(posedge clk); #1;
    w_v3 = 0; r_v3 = 1; idx_r3 = ri;
    @(posedge clk); #1;
    r_v3 = 0;
    check_eq("c3_pv", predict_v3, 1);
    check_eq("c3_pred", predict3, (m3 >= 4) ? 1 : 0);
  endtask

  initial begin
    reset_and_sweep(1'b1);
    check_eq("c3_init_done", init_done3, 1);

    // Every entry reads weakly-not-taken after the sweep.
    for (int i = 0; i < Els; i++) rd(9'(i));
    idle(2);

    // Training up, then down through saturation at 0 and back.
    tr(9'h010, 5'h0, 1'b1); tr(9'h010, 5'h0, 1'b1); rd(9'h010);
    tr(9'h010, 5'h0, 1'b1); rd(9'h010);
    for (int i = 0; i < 4; i++) begin tr(9'h010, 5'h0, 1'b0); rd(9'h010); end
    tr(9'h010, 5'h0, 1'b1); rd(9'h010);
    tr(9'h010, 5'h0, 1'b1); rd(9'h010);

    // Speculative history 1,0,1 -> 00101; lookup 0x000 hashes to 0x005.
    tr(9'h005, 5'h0, 1'b1); tr(9'h005, 5'h0, 1'b1);
    drive(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    drive(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    drive(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    rd(9'h000); rd(9'h005);

    // Lookup with same-cycle spec and restore sees pre-update history.
    drive(1'b1, 9'h000, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b1, 5'h10);
    rd(9'h010); rd(9'h000);

    // Same-cycle read/write of hashed 0x023: old value, then new one.
    drive(1'b1, 9'h033, 1'b1, 9'h030, 5'h13, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    rd(9'h033);
    drive(1'b1, 9'h033, 1'b1, 9'h023, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    rd(9'h033);
    idle(2);

    // Random mixed traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), 9'($urandom_range(0, 63)), 1'($urandom), 9'($urandom_range(0, 63)),
            5'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom),
            ($urandom_range(0, 15) == 0), 5'($urandom));
    end
    drive(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 5'h0b);
    tr(9'h01b, 5'h0b, 1'b1); tr(9'h01b, 5'h0b, 1'b1); rd(9'h010);
    idle(2);
    check_eq("sb_drain_a", sb_q.size(), 0);

    // 3-bit counters: rail at 7, step down, rail at 0, step up.
    m3 = 3;
    for (int i = 0; i < 6; i++) train3_and_read(1'b1, 4'h3);
    for (int i = 0; i < 4; i++) train3_and_read(1'b0, 4'h3);
    for (int i = 0; i < 5; i++) train3_and_read(1'b0, 4'h3);
    for (int i = 0; i < 4; i++) train3_and_read(1'b1, 4'h3);
    check_eq("c3_ghist0", ghist3, 0);
    spec_v3 = 1; spec_taken3 = 1;
    idle(4);
    spec_v3 = 0;
    train3_and_read(1'b1, 4'hc);
    check_eq("c3_ghist", ghist3, 4'hf);

    // Reset mid-traffic (history non-zero), then reset again mid-sweep.
    drive(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    reset_and_sweep(1'b0);
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    idle(200);
    check_eq("midsweep_done", init_done, 0);
    reset_and_sweep(1'b1);
    rd(9'h010); rd(9'h005); rd(9'h01b); rd(9'h000);
    idle(2);
    check_eq("sb_drain_b", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_fe_bht_gshare.md
# bp_fe_bht_gshare

Parametrised gshare branch history table for the front end. It keeps a speculative global history register and a table of N-bit saturating counters indexed by PC-index XOR history. Predictions are registered, and each one returns the history snapshot used to make it. After reset, the block clears itself with a one-entry-per-cycle init sweep. It sits beside the BTB in the fetch stage; resolved branches from the back end train it.

## Interface
- bht_idx_width_p, 9, table index width; els = 2**bht_idx_width_p
- ghist_width_p, 5, global history length; 1 <= ghist_width_p <= bht_idx_width_p
- ctr_width_p, 2, saturating counter width, >= 2

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  synchronous, active-low reset
- init_done_o  out  1  table sweep finished; block accepts traffic
- r_v_i  in  1  prediction lookup request
- idx_r_i  in  bht_idx_width_p  lookup index (PC bits)
- predict_v_o  out  1  prediction valid, one cycle after an accepted r_v_i
- predict_o  out  1  predicted taken
- ghist_o  out  ghist_width_p  history used for this lookup; returned later on ghist_w_i
- spec_v_i  in  1  speculatively shift spec_taken_i into history
- spec_taken_i  in  1  speculative direction
- w_v_i  in  1  train request
- idx_w_i  in  bht_idx_width_p  training index
- ghist_w_i  in  ghist_width_p  history snapshot from the original lookup
- taken_i  in  1  resolved direction
- restore_v_i  in  1  mispredict; overwrite history
- restore_ghist_i  in  ghist_width_p  corrected history (caller already includes the resolved bit)

## Operation
- Hashed index: idx ^ zero-extended history, with history in the low ghist_width_p bits.
  - Reads hash with the current ghist_r.
  - Writes hash with ghist_w_i, never with ghist_r.
- Counter semantics:
  - MSB = predicted direction.
  - taken_i=1 increments the counter; taken_i=0 decrements it.
  - The counter saturates at 0 and at 2**ctr_width_p-1.
  - Init and reset value is weakly-not-taken: 2**(ctr_width_p-1)-1 (2'b01 at default).
- FSM, two states: e_bht_init and e_bht_ready.
  - Reset forces e_bht_init, init pointer = 0, ghist_r = 0.
  - In e_bht_init, one entry is written per cycle. When the pointer reaches els-1 the FSM goes to e_bht_ready and stays there until the next reset.
- While in e_bht_init:
  - init_done_o = 0.
  - r_v_i, w_v_i, spec_v_i and restore_v_i are ignored.
  - predict_v_o = 0.
- History update, applied only in e_bht_ready, in priority order:
  - restore_v_i: ghist_r <= restore_ghist_i.
  - Else spec_v_i: ghist_r <= {ghist_r[ghist_width_p-2:0], spec_taken_i}. With ghist_width_p=1, ghist_r <= spec_taken_i.
  - Else hold.
- Simultaneous events:
  - Read and write to the same hashed index in the same cycle: the read returns the pre-update counter (no bypass). The write commits.
  - spec_v_i in the same cycle as r_v_i: the lookup uses the pre-shift history.
  - restore_v_i in the same cycle as r_v_i: the lookup uses the pre-restore history. The prediction is still issued; the consumer discards it.
- Reset mid-sweep or mid-operation restarts the sweep from entry 0. All history is lost.

## Timing
- Reset values: init_done_o=0, predict_v_o=0, predict_o=0, ghist_o=0.
- Init sweep: reset_n_i rises at edge 0; init_done_o rises after exactly els cycles (512 at default).
- Lookup latency is 1 cycle. predict_v_o, predict_o and ghist_o are registered. predict_v_o is high for exactly one cycle per accepted r_v_i.
- One lookup and one train can be accepted every cycle. There is no backpressure.
- A train takes effect on counter state at the next edge. A read in the following cycle sees the updated value.
- History update takes effect at the next edge.

## Structure
- bp_fe_pkg holds:
  - the enum bp_fe_bht_state_e {e_bht_init, e_bht_ready};
  - the function computing the weakly-not-taken init constant from ctr_width_p.
- Sub-module bp_fe_bht_ctr_sat: combinational, ctr_width_p-parameterised, (ctr_i, taken_i) -> ctr_o saturating increment/decrement.
- Storage: one flop array of els x ctr_width_p with a single write port. The write-port mux priority is init sweep > train.

## Test plan
- Reset, then release -> init_done_o=0 for 512 cycles, then 1. Lookups during the sweep give predict_v_o=0. Every entry then reads not-taken.
- Train idx 0x010 with ghist 0 and taken_i=1 twice -> counter goes 01->10->11. A lookup of 0x010 with ghist_r=0 gives predict_o=1 one cycle after r_v_i.
- Train taken_i=0 three times from 11 -> 10, 01, 00, then stays at 00 (saturation). With ctr_width_p=3, the counter saturates at 7 and at 0.
- spec_v_i with taken=1,0,1 -> ghist_r=5'b00101. A lookup of 0x000 hits entry 0x005 and ghist_o=00101. restore_v_i with 5'b10000 in the same cycle as spec_v_i -> ghist_r=10000.
- Same-cycle read and write to the same hashed entry -> the read returns the old counter MSB. A read the next cycle returns the new MSB.
- Drop reset_n_i low mid-sweep and mid-traffic -> the sweep restarts and runs its full length. All counters return to 01 and ghist_r returns to 0.
